pot_scan_sequencer: RTL and testbench



---
 rtl/pot_scan_sequencer_if.sv | 10 +
 rtl/pot_scan_sequencer.sv | 136 +++++++++++++
 tb/tb_pot_scan_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pot_scan_sequencer_if.sv
// A2D conversion handshake between the pot scan sequencer (master) and the shared A2D block (slave).
interface pot_scan_sequencer_if;
  logic        strt_cnv;
  logic [2:0]  chnl;
  logic        cnv_cmplt;
  logic [11:0] res;

  modport master (output strt_cnv, chnl, input cnv_cmplt, res);
  modport slave  (input strt_cnv, chnl, output cnv_cmplt, res);
endinterface

// File: rtl/pot_scan_sequencer.sv
// Round-robin scan of six slide pots via the shared A2D; results are shadowed and committed together on vld.
// All outputs registered; no backpressure beyond waiting on cnv_cmplt, with a timeout that flags err.
module pot_scan_sequencer #(
  parameter int         SETTLE_CYC  = 16,
  parameter int         TIMEOUT_CYC = 1024,
  parameter logic [2:0] CH_LP  = 3'd1,
  parameter logic [2:0] CH_B1  = 3'd0,
  parameter logic [2:0] CH_B2  = 3'd4,
  parameter logic [2:0] CH_B3  = 3'd2,
  parameter logic [2:0] CH_HP  = 3'd3,
  parameter logic [2:0] CH_VOL = 3'd7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        vld,
  pot_scan_sequencer_if.master        a2d,
  output logic [11:0]                 POT_LP,
  output logic [11:0]                 POT_B1,
  output logic [11:0]                 POT_B2,
  output logic [11:0]                 POT_B3,
  output logic [11:0]                 POT_HP,
  output logic [11:0]                 VOLUME,
  output logic                        pots_rdy,
  output logic                        err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, SETTLE} state_t;

  state_t        state;
  logic [2:0]    idx;
  logic          sweep_done;
  logic [TW-1:0] wait_cnt;
  logic [SW-1:0] settle_cnt;
  logic [11:0]   shadow [6];

  function automatic logic [2:0] ch_of(input logic [2:0] i);
    case (i)
      3'd0:    ch_of = CH_LP;
      3'd1:    ch_of = CH_B1;
      3'd2:    ch_of = CH_B2;
      3'd3:    ch_of = CH_B3;
      3'd4:    ch_of = CH_HP;
      3'd5:    ch_of = CH_VOL;
      default: ch_of = CH_LP;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= 3'd0;
      sweep_done   <= 1'b0;
      wait_cnt     <= '0;
      settle_cnt   <= '0;
      a2d.strt_cnv <= 1'b0;
      a2d.chnl     <= CH_LP;
      POT_LP       <= '0;
      POT_B1       <= '0;
      POT_B2       <= '0;
      POT_B3       <= '0;
      POT_HP       <= '0;
      VOLUME       <= '0;
      pots_rdy     <= 1'b0;
      err          <= 1'b0;
      for (int i = 0; i < 6; i++) shadow[i] <= '0;
    end else begin
      a2d.strt_cnv <= 1'b0;

      // Commit reads the pre-edge shadows; a sweep finishing this same cycle re-arms sweep_done below.
      if (vld && sweep_done) begin
        POT_LP     <= shadow[0];
        POT_B1     <= shadow[1];
        POT_B2     <= shadow[2];
        POT_B3     <= shadow[3];
        POT_HP     <= shadow[4];
        VOLUME     <= shadow[5];
        sweep_done <= 1'b0;
        pots_rdy   <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (en) begin
            state        <= START;
            a2d.strt_cnv <= 1'b1;
          end
        end
        START: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (a2d.cnv_cmplt) begin
            shadow[idx] <= a2d.res;
            settle_cnt  <= '0;
            state       <= SETTLE;
          end else if (wait_cnt == TO_LAST) begin
            err        <= 1'b1;
            settle_cnt <= '0;
            state      <= SETTLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (settle_cnt == ST_LAST) begin
            if (idx == 3'd5) begin
              idx        <= 3'd0;
              a2d.chnl   <= ch_of(3'd0);
              sweep_done <= 1'b1;
            end else begin
              idx      <= idx + 3'd1;
              a2d.chnl <= ch_of(idx + 3'd1);
            end
            if (en) begin
              state        <= START;
              a2d.strt_cnv <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pot_scan_sequencer.sv
// Directed bench: expected channel order queued as scans are enabled, popped on each strt_cnv; pot values checked after commits.
module tb_pot_scan_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic vld = 1'b0;
  logic [11:0] pot_lp, pot_b1, pot_b2, pot_b3, pot_hp, volume;
  logic pots_rdy, err;

  logic        mdl_cmplt = 1'b0;
  logic [11:0] mdl_res   = '0;
  logic        ovr_en    = 1'b0;
  logic        ovr_cmplt = 1'b0;
  logic [11:0] ovr_res   = '0;
  logic [11:0] res_base  = 12'h100;
  int          dead_ch   = -1;

  int checks = 0;
  int errors = 0;
  int n_strt = 0;
  logic [2:0] exp_ch_q [$];

  always #5 clk = ~clk;

  pot_scan_sequencer_if bus ();
  assign bus.cnv_cmplt = ovr_en ? ovr_cmplt : mdl_cmplt;
  assign bus.res       = ovr_en ? ovr_res   : mdl_res;

  pot_scan_sequencer #(.SETTLE_CYC(16), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .en(en), .vld(vld), .a2d(bus),
    .POT_LP(pot_lp), .POT_B1(pot_b1), .POT_B2(pot_b2), .POT_B3(pot_b3),
    .POT_HP(pot_hp), .VOLUME(volume), .pots_rdy(pots_rdy), .err(err)
  );

  // A2D model: answers 0x?00+chnl twenty cycles after a request, except on dead_ch.
  int  a2d_cnt  = 0;
  bit  a2d_busy = 1'b0;
  always @(negedge clk) begin
    mdl_cmplt = 1'b0;
    if (rst) begin
      a2d_busy = 1'b0;
    end else begin
      if (a2d_busy) begin
        a2d_cnt++;
        if (a2d_cnt == 20) begin
          mdl_cmplt = 1'b1;
          mdl_res   = res_base + {9'd0, bus.chnl};
          a2d_busy  = 1'b0;
        end
      end
      if (bus.strt_cnv && int'(bus.chnl) != dead_ch) begin
        a2d_busy = 1'b1;
        a2d_cnt  = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (bus.strt_cnv === 1'b1) begin
      n_strt++;
      if (exp_ch_q.size() == 0) chk("strt_unexpected", 32'(bus.chnl), 32'hFFFF);
      else chk("strt_chnl", 32'(bus.chnl), 32'(exp_ch_q.pop_front()));
    end
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_strt(input int n);
    int budget = 2000;
    while (n_strt < n && budget > 0) begin
      step();
      budget--;
    end
    chk("strt_count", 32'(n_strt), 32'(n));
  endtask

  task automatic push_ch(input logic [2:0] c);
    exp_ch_q.push_back(c);
  endtask

  task automatic push_sweep();
    push_ch(3'd1); push_ch(3'd0); push_ch(3'd4);
    push_ch(3'd2); push_ch(3'd3); push_ch(3'd7);
  endtask

  task automatic pulse_vld();
    vld = 1'b1;
    step();
    vld = 1'b0;
  endtask

  task automatic chk_pots(input string tag, input logic [11:0] lp, b1, b2, b3, hp, vol);
    chk({tag, "_lp"},  32'(pot_lp), 32'(lp));
    chk({tag, "_b1"},  32'(pot_b1), 32'(b1));
    chk({tag, "_b2"},  32'(pot_b2), 32'(b2));
    chk({tag, "_b3"},  32'(pot_b3), 32'(b3));
    chk({tag, "_hp"},  32'(pot_hp), 32'(hp));
    chk({tag, "_vol"}, 32'(volume), 32'(vol));
  endtask

  initial begin
    // Reset state
    wait_n(3);
    chk_pots("rst", 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0);
    chk("rst_strt", 32'(bus.strt_cnv), 32'd0);
    chk("rst_chnl", 32'(bus.chnl), 32'd1);
    chk("rst_rdy", 32'(pots_rdy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // First sweep, early vld must not commit
    rst = 1'b0;
    en  = 1'b1;
    push_sweep();
    wait_strt(6);
    pulse_vld();
    chk_pots("early_vld", 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0);
    chk("early_rdy", 32'(pots_rdy), 32'd0);
    en = 1'b0;
    wait_n(60);
    chk("idle_no_strt", 32'(n_strt), 32'd6);
    pulse_vld();
    chk_pots("sweep1", 12'h101, 12'h100, 12'h104, 12'h102, 12'h103, 12'h107);
    chk("sweep1_rdy", 32'(pots_rdy), 32'd1);

    // Two sweeps with vld held low; one commit of the latest values
    res_base = 12'h200;
    en = 1'b1;
    push_sweep();
    wait_strt(12);
    en = 1'b0;
    wait_n(60);
    chk_pots("no_vld", 12'h101, 12'h100, 12'h104, 12'h102, 12'h103, 12'h107);
    res_base = 12'h300;
    en = 1'b1;
    push_sweep();
    wait_strt(18);
    en = 1'b0;
    wait_n(60);
    pulse_vld();
    chk_pots("sweep3", 12'h301, 12'h300, 12'h304, 12'h302, 12'h303, 12'h307);
    wait_n(5);
    pulse_vld();
    chk_pots("recommit", 12'h301, 12'h300, 12'h304, 12'h302, 12'h303, 12'h307);

    // B2 never answers: terminal WAIT cycle is 64 cycles after the start, err registers on it
    res_base = 12'h400;
    dead_ch  = 4;
    en = 1'b1;
    push_sweep();
    wait_strt(21);
    wait_n(64);
    chk("to_err_before", 32'(err), 32'd0);
    step();
    chk("to_err_after", 32'(err), 32'd1);
    dead_ch = -1;
    wait_strt(24);
    en = 1'b0;
    wait_n(60);
    pulse_vld();
    chk_pots("timeout", 12'h401, 12'h400, 12'h304, 12'h402, 12'h403, 12'h407);
    chk("timeout_err_sticky", 32'(err), 32'd1);

    // en dropped during B1 WAIT; resumes at B2
    res_base = 12'h500;
    en = 1'b1;
    push_ch(3'd1);
    push_ch(3'd0);
    wait_strt(26);
    wait_n(5);
    en = 1'b0;
    wait_n(60);
    chk("en_off_no_strt", 32'(n_strt), 32'd26);
    en = 1'b1;
    push_ch(3'd4); push_ch(3'd2); push_ch(3'd3); push_ch(3'd7);
    wait_strt(30);
    en = 1'b0;
    wait_n(60);
    pulse_vld();
    chk_pots("resume", 12'h501, 12'h500, 12'h504, 12'h502, 12'h503, 12'h507);

    // Reset mid-WAIT after pots_rdy
    en = 1'b1;
    push_ch(3'd1);
    wait_strt(31);
    wait_n(5);
    rst = 1'b1;
    step();
    chk_pots("midrst", 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0);
    chk("midrst_rdy", 32'(pots_rdy), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_strt", 32'(bus.strt_cnv), 32'd0);
    chk("midrst_chnl", 32'(bus.chnl), 32'd1);
    rst = 1'b0;
    push_ch(3'd1);
    wait_strt(32);

    // Completion on the timeout terminal cycle wins; spurious done in SETTLE ignored
    dead_ch = 0;
    push_ch(3'd0); push_ch(3'd4); push_ch(3'd2); push_ch(3'd3); push_ch(3'd7);
    wait_strt(33);
    wait_n(64);
    ovr_en = 1'b1; ovr_cmplt = 1'b1; ovr_res = 12'hABC;
    step();
    ovr_en = 1'b0; ovr_cmplt = 1'b0;
    chk("term_cmplt_err", 32'(err), 32'd0);
    wait_n(3);
    ovr_en = 1'b1; ovr_cmplt = 1'b1; ovr_res = 12'hFFF;
    step();
    ovr_en = 1'b0; ovr_cmplt = 1'b0;
    dead_ch = -1;
    wait_strt(37);
    en = 1'b0;
    wait_n(60);
    pulse_vld();
    chk_pots("term_cmplt", 12'h501, 12'hABC, 12'h504, 12'h502, 12'h503, 12'h507);
    chk("term_cmplt_err_end", 32'(err), 32'd0);
    chk("term_cmplt_rdy", 32'(pots_rdy), 32'd1);
    chk("queue_drained", 32'(exp_ch_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
